// File: rtl/vg_precomp_pkg.sv
// Shared constants, class indices and FSM encoding for the VG93 write-precompensation path.
package vg_precomp_pkg;

  localparam int unsigned DLY_W_DEF   = 4;
  localparam int unsigned PW_DEF      = 7;
  localparam int unsigned DLY_STD_DEF = 7;
  localparam int unsigned DLY_OL_DEF  = 4;
  localparam int unsigned DLY_OR_DEF  = 11;
  localparam int unsigned DLY_IL_DEF  = 0;
  localparam int unsigned DLY_IR_DEF  = 14;
  localparam int unsigned QDEPTH_DEF  = 2;

  localparam int unsigned NCLS = 5;

  localparam logic [2:0] CLS_STD = 3'd0;
  localparam logic [2:0] CLS_OL  = 3'd1;
  localparam logic [2:0] CLS_OR  = 3'd2;
  localparam logic [2:0] CLS_IL  = 3'd3;
  localparam logic [2:0] CLS_IR  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } pc_state_e;

  // Map synced {sl,tr43,sr} to a delay class; anything ambiguous stays nominal.
  function automatic logic [2:0] cls_sel(input logic sl, input logic tr43,
                                         input logic sr, input logic ena);
    logic [2:0] cls;
    cls = CLS_STD;
    if (ena) begin
      case ({sl, tr43, sr})
        3'b100:  cls = CLS_OL;
        3'b001:  cls = CLS_OR;
        3'b110:  cls = CLS_IL;
        3'b011:  cls = CLS_IR;
        default: cls = CLS_STD;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/vg_pq_fifo.sv
// Small synchronous first-word-fall-through FIFO holding pending pulse delays.
module vg_pq_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout_c,
  output logic         full,
  output logic         empty,
  output logic         empty_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // A full queue still accepts a push when the same cycle pops.
  always_comb begin
    do_pop   = pop & ~empty_q;
    do_push  = push & (~full_q | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout_c      = mem_q[rd_ptr_q];
  assign full        = full_q;
  assign empty       = empty_q;
  assign empty_nxt_c = empty_d;

endmodule

// File: rtl/vg_wrprecomp.sv
// Write precompensation and pulse shaper between VG93 WD/SL/SR/TR43 and the drive.
// Define VG_PRECOMP_CFG_EN to make the delay table runtime-programmable.
module vg_wrprecomp
  import vg_precomp_pkg::*;
#(
  parameter int unsigned DLY_W   = DLY_W_DEF,
  parameter int unsigned PW      = PW_DEF,
  parameter int unsigned DLY_STD = DLY_STD_DEF,
  parameter int unsigned DLY_OL  = DLY_OL_DEF,
  parameter int unsigned DLY_OR  = DLY_OR_DEF,
  parameter int unsigned DLY_IL  = DLY_IL_DEF,
  parameter int unsigned DLY_IR  = DLY_IR_DEF,
  parameter int unsigned QDEPTH  = QDEPTH_DEF
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             vg_wd,
  input  logic             vg_sl,
  input  logic             vg_sr,
  input  logic             vg_tr43,
  input  logic             precomp_ena,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_sel,
  input  logic [DLY_W-1:0] cfg_data,
  output logic             vg_wrd,
  output logic             busy,
  output logic             ovf
);

  logic [2:0]       wd_s_q, wd_s_d;
  logic [1:0]       sl_s_q, sl_s_d;
  logic [1:0]       sr_s_q, sr_s_d;
  logic [1:0]       tr_s_q, tr_s_d;
  pc_state_e        state_q, state_d;
  logic [DLY_W-1:0] dcnt_q, dcnt_d;
  logic [DLY_W-1:0] pcnt_q, pcnt_d;
  logic             vg_wrd_q, vg_wrd_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [DLY_W-1:0] tbl [NCLS];
  logic [DLY_W-1:0] dly_sel;
  logic [2:0]       cls;
  logic             strobe, launch, push, pop;
  logic [DLY_W-1:0] q_head;
  logic             q_full, q_empty, q_empty_nxt;

`ifdef VG_PRECOMP_CFG_EN
  logic [DLY_W-1:0] tbl_q [NCLS];
  logic [DLY_W-1:0] tbl_d [NCLS];

  // Indices 5..7 are silently ignored.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && (cfg_sel < 3'(NCLS))) tbl_d[cfg_sel] = cfg_data;
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      tbl_q[CLS_STD] <= DLY_W'(DLY_STD);
      tbl_q[CLS_OL]  <= DLY_W'(DLY_OL);
      tbl_q[CLS_OR]  <= DLY_W'(DLY_OR);
      tbl_q[CLS_IL]  <= DLY_W'(DLY_IL);
      tbl_q[CLS_IR]  <= DLY_W'(DLY_IR);
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NCLS); i++) tbl[i] = tbl_q[i];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_sel, cfg_data};

  always_comb begin
    tbl[CLS_STD] = DLY_W'(DLY_STD);
    tbl[CLS_OL]  = DLY_W'(DLY_OL);
    tbl[CLS_OR]  = DLY_W'(DLY_OR);
    tbl[CLS_IL]  = DLY_W'(DLY_IL);
    tbl[CLS_IR]  = DLY_W'(DLY_IR);
  end
`endif

  vg_pq_fifo #(
    .W     (DLY_W),
    .DEPTH (QDEPTH)
  ) u_pq (
    .clk         (fclk),
    .rst         (rst),
    .push        (push),
    .din         (dly_sel),
    .pop         (pop),
    .dout_c      (q_head),
    .full        (q_full),
    .empty       (q_empty),
    .empty_nxt_c (q_empty_nxt)
  );

  // Synchronisers, strobe detect, class select and the delay/pulse sequencer.
  always_comb begin
    wd_s_d  = {wd_s_q[1:0], vg_wd};
    sl_s_d  = {sl_s_q[0], vg_sl};
    sr_s_d  = {sr_s_q[0], vg_sr};
    tr_s_d  = {tr_s_q[0], vg_tr43};
    strobe  = wd_s_q[1] & ~wd_s_q[2];
    cls     = cls_sel(sl_s_q[1], tr_s_q[1], sr_s_q[1], precomp_ena);
    dly_sel = tbl[cls];
    push    = strobe;

    state_d = state_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    pop     = 1'b0;
    launch  = 1'b0;

    unique case (state_q)
      ST_IDLE: launch = ~q_empty;
      ST_DELAY: begin
        dcnt_d = dcnt_q - DLY_W'(1);
        if (dcnt_q == DLY_W'(1)) begin
          state_d = ST_PULSE;
          pcnt_d  = DLY_W'(PW);
        end
      end
      ST_PULSE: begin
        pcnt_d = pcnt_q - DLY_W'(1);
        if (pcnt_q == DLY_W'(1)) begin
          state_d = ST_IDLE;
          launch  = ~q_empty;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Zero delay skips DELAY entirely so latency stays delay + 2.
    if (launch) begin
      pop = 1'b1;
      if (q_head == '0) begin
        state_d = ST_PULSE;
        pcnt_d  = DLY_W'(PW);
      end else begin
        state_d = ST_DELAY;
        dcnt_d  = q_head;
      end
    end

    ovf_d = ovf_q | (strobe & q_full & ~pop);
  end

  assign vg_wrd_d = (state_d == ST_PULSE);
  assign busy_d   = (state_d != ST_IDLE) | ~q_empty_nxt;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      wd_s_q   <= '0;
      sl_s_q   <= '0;
      sr_s_q   <= '0;
      tr_s_q   <= '0;
      state_q  <= ST_IDLE;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      vg_wrd_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wd_s_q   <= wd_s_d;
      sl_s_q   <= sl_s_d;
      sr_s_q   <= sr_s_d;
      tr_s_q   <= tr_s_d;
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      vg_wrd_q <= vg_wrd_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign vg_wrd = vg_wrd_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_vg_wrprecomp.sv
// Directed bench for vg_wrprecomp: latency, pulse width, queueing, overflow and reset abort.
module tb_vg_wrprecomp;

  localparam int unsigned DLY_W = 4;

  logic             fclk = 1'b0;
  logic             rst = 1'b1;
  logic             vg_wd = 1'b0;
  logic             vg_sl = 1'b0;
  logic             vg_sr = 1'b0;
  logic             vg_tr43 = 1'b0;
  logic             precomp_ena = 1'b1;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_sel = 3'd0;
  logic [DLY_W-1:0] cfg_data = '0;
  logic             vg_wrd, busy, ovf;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   rise_q[$];
  int   fall_q[$];
  logic wrd_prev = 1'b0;

  vg_wrprecomp dut (
    .fclk        (fclk),
    .rst         (rst),
    .vg_wd       (vg_wd),
    .vg_sl       (vg_sl),
    .vg_sr       (vg_sr),
    .vg_tr43     (vg_tr43),
    .precomp_ena (precomp_ena),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .vg_wrd      (vg_wrd),
    .busy        (busy),
    .ovf         (ovf)
  );

  initial forever #5 fclk = ~fclk;

  // cyc == k during the cycle that follows posedge number k.
  initial forever begin
    @(posedge fclk);
    cyc++;
  end

  // Record the cycle of every vg_wrd rise and of the first low cycle after a pulse.
  initial forever begin
    @(negedge fclk);
    if (vg_wrd && !wrd_prev) rise_q.push_back(cyc);
    if (!vg_wrd && wrd_prev) fall_q.push_back(cyc);
    wrd_prev = vg_wrd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle WD pulse; s is the resulting strobe cycle (3-flop sync puts it 2 cycles later).
  task automatic do_strobe(output int s);
    @(posedge fclk); #1;
    vg_wd = 1'b1;
    s = cyc + 2;
    @(posedge fclk); #1;
    vg_wd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge fclk);
      n++;
    end
    if (busy) check_val({tag, "_timeout"}, 1, 0);
    repeat (2) @(posedge fclk);
    #1;
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
  endtask

  task automatic run_one(input string tag, input logic sl, input logic tr, input logic sr,
                         input logic ena, input int exp_lat);
    int s;
    vg_sl = sl;
    vg_tr43 = tr;
    vg_sr = sr;
    precomp_ena = ena;
    repeat (4) @(posedge fclk);
    #1;
    clear_mon();
    do_strobe(s);
    repeat (3) @(posedge fclk);
    #1;
    wait_idle(tag);
    check_val({tag, "_npulse"}, rise_q.size(), 1);
    if (rise_q.size() >= 1 && fall_q.size() >= 1) begin
      check_val({tag, "_lat"}, rise_q[0] - s, exp_lat);
      check_val({tag, "_pw"}, fall_q[0] - rise_q[0], 7);
    end
    check_val({tag, "_ovf"}, int'(ovf), 0);
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [DLY_W-1:0] data);
    @(posedge fclk); #1;
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_data = data;
    @(posedge fclk); #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    int s0, s1, s2, s3, n;

    repeat (3) @(posedge fclk);
    #1;
    check_val("rst_wrd", int'(vg_wrd), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    repeat (3) @(posedge fclk);
    #1;

    // Class selection: {sl,tr43,sr}
    run_one("std",   1'b0, 1'b0, 1'b0, 1'b1, 9);
    run_one("ol",    1'b1, 1'b0, 1'b0, 1'b1, 6);
    run_one("or",    1'b0, 1'b0, 1'b1, 1'b1, 13);
    run_one("il",    1'b1, 1'b1, 1'b0, 1'b1, 2);
    run_one("ir",    1'b0, 1'b1, 1'b1, 1'b1, 16);
    run_one("noena", 1'b0, 1'b0, 1'b1, 1'b0, 9);
    run_one("slsr",  1'b1, 1'b0, 1'b1, 1'b1, 9);

    // Two strobes 4 cycles apart: second queued, follows first with no idle gap.
    vg_sl = 1'b0; vg_sr = 1'b0; vg_tr43 = 1'b0; precomp_ena = 1'b1;
    repeat (4) @(posedge fclk);
    #1;
    clear_mon();
    do_strobe(s0);
    repeat (2) @(posedge fclk);
    do_strobe(s1);
    check_val("two_spacing", s1 - s0, 4);
    repeat (3) @(posedge fclk);
    #1;
    wait_idle("two");
    check_val("two_npulse", rise_q.size(), 2);
    if (rise_q.size() >= 2 && fall_q.size() >= 2) begin
      check_val("two_lat0", rise_q[0] - s0, 9);
      check_val("two_lat1", rise_q[1] - s0, 23);
      check_val("two_gap", rise_q[1] - fall_q[0], 7);
      check_val("two_pw1", fall_q[1] - rise_q[1], 7);
    end
    check_val("two_ovf", int'(ovf), 0);

    // Three strobes during the first delay with QDEPTH=2: one is dropped.
    clear_mon();
    do_strobe(s0);
    do_strobe(s1);
    do_strobe(s2);
    do_strobe(s3);
    check_val("burst_spacing", s3 - s0, 6);
    repeat (3) @(posedge fclk);
    #1;
    check_val("burst_ovf_early", int'(ovf), 1);
    wait_idle("burst");
    check_val("burst_npulse", rise_q.size(), 3);
    if (rise_q.size() >= 3 && fall_q.size() >= 3) begin
      check_val("burst_lat0", rise_q[0] - s0, 9);
      check_val("burst_lat1", rise_q[1] - s0, 23);
      check_val("burst_lat2", rise_q[2] - s0, 37);
      check_val("burst_pw2", fall_q[2] - rise_q[2], 7);
    end
    repeat (10) @(posedge fclk);
    #1;
    check_val("burst_ovf_sticky", int'(ovf), 1);

`ifdef VG_PRECOMP_CFG_EN
    cfg_write(3'd0, DLY_W'(3));
    run_one("cfg_std3", 1'b0, 1'b0, 1'b0, 1'b1, 5);
    cfg_write(3'd0, DLY_W'(7));
    // Write landing in the strobe cycle must not affect that strobe.
    clear_mon();
    do_strobe(s0);
    @(posedge fclk); #1;
    cfg_we = 1'b1;
    cfg_sel = 3'd0;
    cfg_data = DLY_W'(3);
    @(posedge fclk); #1;
    cfg_we = 1'b0;
    repeat (2) @(posedge fclk);
    #1;
    wait_idle("cfg_same");
    check_val("cfg_same_npulse", rise_q.size(), 1);
    if (rise_q.size() >= 1) check_val("cfg_same_lat", rise_q[0] - s0, 9);
    clear_mon();
    do_strobe(s1);
    repeat (3) @(posedge fclk);
    #1;
    wait_idle("cfg_after");
    if (rise_q.size() >= 1) check_val("cfg_after_lat", rise_q[0] - s1, 5);
    else check_val("cfg_after_npulse", rise_q.size(), 1);
    cfg_write(3'd4, DLY_W'(2));
    clear_mon();
    vg_sr = 1'b1; vg_tr43 = 1'b1;
    repeat (4) @(posedge fclk);
    do_strobe(s2);
    repeat (3) @(posedge fclk);
    #1;
    wait_idle("cfg_ir");
    if (rise_q.size() >= 1) check_val("cfg_ir_lat", rise_q[0] - s2, 4);
    else check_val("cfg_ir_npulse", rise_q.size(), 1);
    vg_sr = 1'b0; vg_tr43 = 1'b0;
`else
    cfg_write(3'd0, DLY_W'(3));
    clear_mon();
    repeat (4) @(posedge fclk);
    do_strobe(s0);
    repeat (3) @(posedge fclk);
    #1;
    wait_idle("cfg_ign");
    if (rise_q.size() >= 1) check_val("cfg_ign_lat", rise_q[0] - s0, 9);
    else check_val("cfg_ign_npulse", rise_q.size(), 1);
`endif

    // Reset mid-pulse with a second entry queued: everything aborts.
    clear_mon();
    do_strobe(s0);
    do_strobe(s1);
    n = 0;
    while (!vg_wrd && n < 40) begin
      @(negedge fclk);
      n++;
    end
    check_val("rstp_seen", int'(vg_wrd), 1);
    @(negedge fclk);
    @(negedge fclk);
    #2;
    rst = 1'b1;
    #1;
    check_val("rstp_wrd", int'(vg_wrd), 0);
    check_val("rstp_busy", int'(busy), 0);
    check_val("rstp_ovf", int'(ovf), 0);
    repeat (3) @(posedge fclk);
    #1;
    rst = 1'b0;
    clear_mon();
    repeat (40) @(posedge fclk);
    #1;
    check_val("rstp_npulse", rise_q.size(), 0);
    check_val("rstp_busy_after", int'(busy), 0);

    // Table and status are back to defaults after reset.
    run_one("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vg_wrprecomp.md
Name: vg_wrprecomp

Overview:
- Parametrised write-precompensation and write-pulse shaper for the VG93 floppy path.
- Runs on the 28 MHz fpga clock and sits between the controller's WD/SL/SR/TR43 outputs and the drive write-data line.
- Extends the fixed single-shot scheme:
  - parametrised delay and pulse widths;
  - a small pending-pulse queue, so WD strobes arriving during an active delay or pulse are not lost;
  - overflow flag and busy status;
  - optional runtime-programmable delay table.

Parameters:
- DLY_W, 4: width of delay values and delay counter.
- PW, 7: vg_wrd pulse length in fclk cycles, 1..2**DLY_W-1.
- DLY_STD, 7: delay for no-shift, or when precomp_ena=0.
- DLY_OL, 4: delay for shift-left, outer tracks.
- DLY_OR, 11: delay for shift-right, outer tracks.
- DLY_IL, 0: delay for shift-left, inner tracks.
- DLY_IR, 14: delay for shift-right, inner tracks.
- QDEPTH, 2: pending-pulse queue depth, power of two, ≥2.

Ports:
- fclk  in  1  28 MHz clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- vg_wd  in  1  raw WD from VG93, asynchronous.
- vg_sl  in  1  shift-left request, asynchronous.
- vg_sr  in  1  shift-right request, asynchronous.
- vg_tr43  in  1  inner-track flag, asynchronous.
- precomp_ena  in  1  1 = apply class delays; 0 = always DLY_STD.
- cfg_we  in  1  table write strobe (feature VG_PRECOMP_CFG_EN only).
- cfg_sel  in  3  table index: 0 STD, 1 OL, 2 OR, 3 IL, 4 IR; 5..7 ignored.
- cfg_data  in  DLY_W  table write value.
- vg_wrd  out  1  shaped, delayed write pulse to drive.
- busy  out  1  FSM not IDLE, or queue non-empty.
- ovf  out  1  sticky: a strobe was dropped because the queue was full.

Behaviour:
- Reset (async, rst=1):
  - vg_wrd=0, busy=0, ovf=0.
  - FSM=IDLE, queue empty, all sync flops 0.
  - Table loads parameter defaults.
  - Reset mid-delay or mid-pulse aborts immediately; no residual pulse after release.
- Synchronisers:
  - sl, sr, tr43: 2 flops each.
  - wd: 3 flops; strobe = wd_s[1] & ~wd_s[2], one cycle per rising edge.
- Class select, sampled in the strobe cycle from synced {sl,tr43,sr}:
  - 100 → OL; 001 → OR; 110 → IL; 011 → IR; anything else → STD.
  - precomp_ena=0 forces STD.
- Queue: the selected delay value is pushed on strobe. The in-flight value is fixed at push time; later table or class changes do not alter queued entries.
- Full queue with no pop in the same cycle: the strobe is dropped and ovf is set. ovf clears only on rst.
- Simultaneous push and pop on a full queue: the push is accepted.
- FSM states:
  - IDLE: if the queue is non-empty, pop, load dcnt with the popped value and go to DELAY. If the popped value is 0, go straight to PULSE with pcnt=PW.
  - DELAY: dcnt decrements each cycle. When dcnt==1, go to PULSE and load pcnt=PW.
  - PULSE: vg_wrd=1 (registered output); pcnt decrements. When pcnt==1, vg_wrd drops next cycle and the FSM goes to IDLE, or directly to DELAY/PULSE if the queue is non-empty (back-to-back, no gap cycle).
- Latency, from the strobe cycle to the first vg_wrd=1 cycle: delay + 2 fclk (push, pop/load). Pulse is exactly PW cycles wide.
- A strobe arriving while vg_wrd is high is queued, never merged.
- busy is registered and reflects the state after each edge.

Optional Feature:
- Macro: VG_PRECOMP_CFG_EN.
- Defined:
  - The 5-entry table is held in flops.
  - cfg_we writes cfg_data to entry cfg_sel; the write takes effect for strobes from the next cycle on.
  - A write in the same cycle as a strobe uses the old value.
- Undefined:
  - The table is the parameter constants.
  - cfg_we, cfg_sel and cfg_data are ignored and remain only as ports.

Decomposition:
- Package vg_precomp_pkg:
  - class index localparams (CLS_STD..CLS_IR);
  - FSM state encoding (IDLE, DELAY, PULSE);
  - default delay constants shared with vg93.
- One sub-module: vg_pq_fifo, a parametrised synchronous FIFO (DLY_W wide, QDEPTH deep, full/empty, concurrent push/pop).

Test Plan:
- Single strobe, sl=sr=tr43=0, defaults → vg_wrd high 7 cycles, rising 9 fclk after the strobe cycle.
- sl=1,tr43=1 (IL, delay 0) → rise 2 cycles after strobe. sr=1,tr43=1 (IR, 14) → rise 16 cycles after. precomp_ena=0 with sr=1 → 9 cycles.
- Two strobes 4 cycles apart, STD → two 7-cycle pulses; the second is queued and follows the first with no gap; ovf=0.
- Three strobes within the first delay, QDEPTH=2 → two pulses after the first pulse, one dropped, ovf=1 until rst.
- Assert rst mid-PULSE → vg_wrd=0 asynchronously, busy=0; no pulse after release without a new strobe.
- With VG_PRECOMP_CFG_EN: write cfg_sel=0, data=3, then strobe → rise 5 cycles after strobe. Same write in the strobe cycle → old delay 7.
